// File: rtl/pf_pkg.sv
// Shared types and constants for the playfield tile fetch path.
package pf_pkg;

  localparam int PF_ROM_AW = 11;
  localparam int PF_TILE_W = 8;
  localparam int PF_ROW_W  = 3;
  localparam int PF_PAL_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT
  } pf_fetch_state_e;

  typedef struct packed {
    logic [PF_TILE_W-1:0] code;
    logic [PF_ROW_W-1:0]  row;
    logic [PF_PAL_W-1:0]  pal;
    logic                 flipx;
  } pf_tile_desc_t;

  function automatic logic [PF_TILE_W-1:0] pf_rev8(input logic [PF_TILE_W-1:0] b);
    logic [PF_TILE_W-1:0] r;
    for (int i = 0; i < PF_TILE_W; i++) r[i] = b[PF_TILE_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/pf_pix_shifter.sv
// 2bpp pixel serializer: two plane shift registers, remaining-count and sticky underrun.
module pf_pix_shifter #(
  parameter int PAL_W = 4
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             ce_pix_i,
  input  logic             buf_full_i,
  input  logic [7:0]       buf_p0_i,
  input  logic [7:0]       buf_p1_i,
  input  logic [PAL_W-1:0] buf_pal_i,
  output logic             reload_o,
  output logic [1:0]       pix_o,
  output logic [PAL_W-1:0] pix_pal_o,
  output logic             pix_valid_o,
  output logic             underrun_o
);

  logic [7:0]       p0_q, p1_q;
  logic [PAL_W-1:0] pal_q;
  logic [3:0]       cnt_q;
  logic             und_q;
  logic             load;

  assign load     = ce_pix_i && (cnt_q <= 4'd1) && buf_full_i;
  assign reload_o = load && !flush_i && !reset_i;

  always_ff @(posedge clk) begin
    if (reset_i || flush_i) begin
      cnt_q <= 4'd0;
      und_q <= 1'b0;
    end else if (ce_pix_i) begin
      if (load) begin
        cnt_q <= 4'd8;
      end else if (cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
        // Last pixel leaving with nothing buffered behind it.
        if (cnt_q == 4'd1) und_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ce_pix_i) begin
      if (load) begin
        p0_q  <= buf_p0_i;
        p1_q  <= buf_p1_i;
        pal_q <= buf_pal_i;
      end else begin
        p0_q <= {p0_q[6:0], 1'b0};
        p1_q <= {p1_q[6:0], 1'b0};
      end
    end
  end

  assign pix_valid_o = (cnt_q != 4'd0);
  assign pix_o       = pix_valid_o ? {p1_q[7], p0_q[7]} : 2'b00;
  assign pix_pal_o   = pix_valid_o ? pal_q : '0;
  assign underrun_o  = und_q;

endmodule

// File: rtl/pf_tile_fetch.sv
// Playfield tile fetch FSM, ROM address register and one-tile buffer feeding the pixel shifter.
// Horizontal flip is built only when PF_FLIPX_EN is defined.
module pf_tile_fetch
  import pf_pkg::*;
#(
  parameter int PAL_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce_pix,
  input  logic                 flush,
  input  logic                 tile_valid,
  output logic                 tile_ready,
  input  logic [PF_TILE_W-1:0] tile_code,
  input  logic [PF_ROW_W-1:0]  tile_row,
  input  logic [PAL_W-1:0]     tile_pal,
  input  logic                 tile_flipx,
  output logic [PF_ROM_AW-1:0] rom_a,
  input  logic [7:0]           rom0_d,
  input  logic [7:0]           rom1_d,
  output logic [1:0]           pix,
  output logic [PAL_W-1:0]     pix_pal,
  output logic                 pix_valid,
  output logic                 underrun
);

  pf_fetch_state_e      state_q;
  logic [PF_ROM_AW-1:0] rom_a_q;
  logic [PAL_W-1:0]     pal_q;
  logic                 buf_full_q;
  logic [7:0]           buf_p0_q, buf_p1_q;
  logic [7:0]           buf_p0_d, buf_p1_d;
  logic                 accept;
  logic                 reload;

  assign tile_ready = (state_q == ST_IDLE) && !buf_full_q && !flush && !reset;
  assign accept     = tile_valid && tile_ready;
  assign rom_a      = rom_a_q;

`ifdef PF_FLIPX_EN
  logic flip_q;
  // Reversal happens once at capture so the shifter always runs MSB first.
  assign buf_p0_d = flip_q ? pf_rev8(rom0_d) : rom0_d;
  assign buf_p1_d = flip_q ? pf_rev8(rom1_d) : rom1_d;

  always_ff @(posedge clk) begin
    if (accept) flip_q <= tile_flipx;
  end
`else
  logic unused_flipx;
  assign unused_flipx = tile_flipx;
  assign buf_p0_d     = rom0_d;
  assign buf_p1_d     = rom1_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      buf_full_q <= 1'b0;
      rom_a_q    <= '0;
    end else if (flush) begin
      state_q    <= ST_IDLE;
      buf_full_q <= 1'b0;
    end else begin
      if (reload) buf_full_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            rom_a_q <= {tile_code, tile_row};
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: state_q <= ST_WAIT;
        ST_WAIT: begin
          buf_full_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Buffer data needs no reset: buf_full_q gates every use of it.
  always_ff @(posedge clk) begin
    if (accept) pal_q <= tile_pal;
    if (state_q == ST_WAIT) begin
      buf_p0_q <= buf_p0_d;
      buf_p1_q <= buf_p1_d;
    end
  end

  pf_pix_shifter #(
    .PAL_W(PAL_W)
  ) u_shifter (
    .clk        (clk),
    .reset_i    (reset),
    .flush_i    (flush),
    .ce_pix_i   (ce_pix),
    .buf_full_i (buf_full_q),
    .buf_p0_i   (buf_p0_q),
    .buf_p1_i   (buf_p1_q),
    .buf_pal_i  (pal_q),
    .reload_o   (reload),
    .pix_o      (pix),
    .pix_pal_o  (pix_pal),
    .pix_valid_o(pix_valid),
    .underrun_o (underrun)
  );

endmodule

// File: tb/tb_pf_tile_fetch.sv
// Self-checking bench for pf_tile_fetch: vector table, scoreboard and multi-cycle corner sequences.
module tb_pf_tile_fetch;

  localparam int PAL_W = 4;
`ifdef PF_FLIPX_EN
  localparam bit FLIP_EN = 1'b1;
`else
  localparam bit FLIP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             ce_pix = 1'b1;
  logic             flush = 1'b0;
  logic             tile_valid = 1'b0;
  logic             tile_ready;
  logic [7:0]       tile_code = 8'h00;
  logic [2:0]       tile_row = 3'd0;
  logic [PAL_W-1:0] tile_pal = '0;
  logic             tile_flipx = 1'b0;
  logic [10:0]      rom_a;
  logic [7:0]       rom0_d = 8'h00;
  logic [7:0]       rom1_d = 8'h00;
  logic [1:0]       pix;
  logic [PAL_W-1:0] pix_pal;
  logic             pix_valid;
  logic             underrun;

  always #5 clk = ~clk;

  pf_tile_fetch #(.PAL_W(PAL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .ce_pix    (ce_pix),
    .flush     (flush),
    .tile_valid(tile_valid),
    .tile_ready(tile_ready),
    .tile_code (tile_code),
    .tile_row  (tile_row),
    .tile_pal  (tile_pal),
    .tile_flipx(tile_flipx),
    .rom_a     (rom_a),
    .rom0_d    (rom0_d),
    .rom1_d    (rom1_d),
    .pix       (pix),
    .pix_pal   (pix_pal),
    .pix_valid (pix_valid),
    .underrun  (underrun)
  );

  function automatic logic [7:0] rom0_f(input logic [10:0] a);
    if (a == 11'h093) return 8'hA5;
    return a[7:0] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] rom1_f(input logic [10:0] a);
    if (a == 11'h093) return 8'h0F;
    return {a[2:0], a[10:6]} ^ 8'hC1;
  endfunction

  // Registered plane ROMs, one cycle of latency.
  always @(posedge clk) begin
    rom0_d <= rom0_f(rom_a);
    rom1_d <= rom1_f(rom_a);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]       pix;
    logic [PAL_W-1:0] pal;
  } px_t;

  px_t sb_q[$];

  function automatic void push_tile(input logic [10:0] a, input logic [PAL_W-1:0] pal, input logic flip);
    logic [7:0] r0, r1;
    int b;
    r0 = rom0_f(a);
    r1 = rom1_f(a);
    for (int i = 0; i < 8; i++) begin
      b = (flip && FLIP_EN) ? i : 7 - i;
      sb_q.push_back('{pix: {r1[b], r0[b]}, pal: pal});
    end
  endfunction

  logic ce_last = 1'b0;
  always @(posedge clk) begin
    ce_last <= ce_pix;
    if (reset || flush) sb_q.delete();
    else if (tile_valid && tile_ready) push_tile({tile_code, tile_row}, tile_pal, tile_flipx);
  end

  bit mon_en = 1'b0;
  int run_len = 0;
  int last_run = 0;
  bit und_while_valid = 1'b0;
  px_t exp_px;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pix_valid) begin
        if (ce_last) begin
          check("sb_nonempty", (sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            exp_px = sb_q.pop_front();
            check("sb_pix", pix, exp_px.pix);
            check("sb_pal", pix_pal, exp_px.pal);
          end
        end
        if (underrun) und_while_valid = 1'b1;
        run_len++;
      end else begin
        check("gated_out", {pix, pix_pal}, 0);
        if (run_len != 0) last_run = run_len;
        run_len = 0;
      end
    end
  end

  bit rand_ce = 1'b0;
  always @(negedge clk) ce_pix = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;

  bit rdy_win = 1'b0;
  int rdy_cnt = 0;
  always @(negedge clk) begin
    #2;
    if (rdy_win && tile_ready) rdy_cnt++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_tile(input logic [7:0] code, input logic [2:0] row,
                           input logic [PAL_W-1:0] pal, input logic flip);
    bit ok;
    ok = 1'b0;
    tile_code  = code;
    tile_row   = row;
    tile_pal   = pal;
    tile_flipx = flip;
    tile_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (tile_ready) ok = 1'b1;
      @(negedge clk);
    end
    check("accept_in_time", ok, 1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!pix_valid && n < 40) begin tick(); n++; end
    check(name, pix_valid, 1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!pix_valid && n < 40) begin tick(); n++; end
    while (pix_valid && n < 300) begin tick(); n++; end
    check(name, (n < 300), 1);
  endtask

  task automatic pix_seq(input logic flip, input string name);
    logic [1:0] seq_norm[8];
    logic [1:0] seq_flip[8];
    logic [1:0] e;
    seq_norm = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3};
    seq_flip = '{2'd3, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1};
    send_tile(8'h12, 3'd3, 4'h6, flip);
    tile_valid = 1'b0;
    wait_valid({name, "_start"});
    for (int i = 0; i < 8; i++) begin
      e = (flip && FLIP_EN) ? seq_flip[i] : seq_norm[i];
      check({name, "_pix"}, pix, e);
      check({name, "_pal"}, pix_pal, 4'h6);
      check({name, "_valid"}, pix_valid, 1);
      tick();
    end
    check({name, "_valid_end"}, pix_valid, 0);
    do_flush();
  endtask

  typedef struct {
    logic [7:0]       code;
    logic [2:0]       row;
    logic [PAL_W-1:0] pal;
    logic             flip;
    logic [10:0]      exp_a;
  } vec_t;

  vec_t vecs[6];
  bit   seen;

  initial begin
    vecs[0] = '{8'h12, 3'd3, 4'h6, 1'b0, 11'h093};
    vecs[1] = '{8'h12, 3'd3, 4'h6, 1'b1, 11'h093};
    vecs[2] = '{8'hFF, 3'd7, 4'hF, 1'b0, 11'h7FF};
    vecs[3] = '{8'h00, 3'd0, 4'h0, 1'b1, 11'h000};
    vecs[4] = '{8'hA5, 3'd5, 4'h9, 1'b0, 11'h52D};
    vecs[5] = '{8'h3C, 3'd1, 4'h3, 1'b1, 11'h1E1};

    repeat (3) tick();
    check("rst_rom_a", rom_a, 0);
    check("rst_ready", tile_ready, 0);
    check("rst_pix", pix, 0);
    check("rst_pix_pal", pix_pal, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_underrun", underrun, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick();
    check("ready_after_reset", tile_ready, 1);

    for (int v = 0; v < 6; v++) begin
      send_tile(vecs[v].code, vecs[v].row, vecs[v].pal, vecs[v].flip);
      tile_valid = 1'b0;
      check("vec_rom_a", rom_a, vecs[v].exp_a);
      wait_drain("vec_drain");
      tick();
      check("vec_sb_empty", sb_q.size(), 0);
      check("vec_underrun_set", underrun, 1);
      do_flush();
      check("vec_underrun_clr", underrun, 0);
    end

    pix_seq(1'b0, "order");
    pix_seq(1'b1, "flip");

    last_run = 0;
    und_while_valid = 1'b0;
    rdy_cnt = 0;
    rdy_win = 1'b1;
    for (int t = 0; t < 4; t++) send_tile(8'h40 + 8'(t), 3'(t), 4'(t + 1), 1'b0);
    rdy_win = 1'b0;
    tile_valid = 1'b0;
    wait_drain("b2b_drain");
    tick();
    check("b2b_run_len", last_run, 32);
    check("b2b_no_underrun", und_while_valid, 0);
    check("b2b_ready_pulses", rdy_cnt, 4);
    do_flush();

    send_tile(8'h77, 3'd2, 4'h5, 1'b0);
    tile_valid = 1'b0;
    wait_valid("under_start");
    repeat (8) tick();
    check("under_valid", pix_valid, 0);
    check("under_pix", pix, 0);
    check("under_flag", underrun, 1);
    repeat (5) tick();
    check("under_sticky", underrun, 1);
    do_flush();
    check("under_flush_clr", underrun, 0);

    send_tile(8'h55, 3'd4, 4'hA, 1'b0);
    tile_valid = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    check("flush_ready_low", tile_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_ready_after", tile_ready, 1);
    seen = 1'b0;
    repeat (15) begin
      tick();
      if (pix_valid) seen = 1'b1;
    end
    check("flush_no_pixels", seen, 0);
    check("flush_underrun", underrun, 0);

    rand_ce = 1'b1;
    for (int t = 0; t < 3; t++) send_tile(8'hC0 + 8'(t), 3'(7 - t), 4'(9 + t), 1'(t));
    tile_valid = 1'b0;
    wait_drain("rce_drain");
    rand_ce = 1'b0;
    repeat (2) tick();
    check("rce_sb_empty", sb_q.size(), 0);
    do_flush();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
